// File: rtl/rca_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry adder.
// State encoding and default slice width.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_DEF = 4;

endpackage

// File: rtl/rca_slice4.sv
// Combinational ripple-carry adder slice.
// Built from a chain of full-adder cells.
module rca_slice4
  import rca_pkg::*;
#(
  parameter int W = SLICE_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i])
                   | (c[i] & (a[i] ^ b[i]));
  end

  assign carry = c[W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle wide adder: one narrow slice reused LSB first,
// with the carry held in carry_r between slice cycles.
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW =
    (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NSLICE - 1);

  state_t state, nstate;

  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry_r;

  logic [SLICE-1:0] sa, sb, ss;
  logic             sc;

  assign sa = a_r[idx*SLICE +: SLICE];
  assign sb = b_r[idx*SLICE +: SLICE];

  rca_slice4 #(.W(SLICE)) u_slice (
    .a     (sa),
    .b     (sb),
    .cin   (carry_r),
    .sum   (ss),
    .carry (sc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (start) nstate = RUN;
      RUN:  if (idx == LAST) nstate = DONE;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // idx parks on the last slice; it is reloaded on every accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= cin;
      idx     <= '0;
      sum     <= '0;
    end else if (state == RUN) begin
      sum[idx*SLICE +: SLICE] <= ss;
      carry_r <= sc;
      if (idx == LAST) cout <= sc;
      else             idx  <= idx + 1'b1;
    end
  end

endmodule
